sram_word_controller: RTL and testbench
=======================================

# sram_word_controller

Sequences the board's 16-bit asynchronous SRAM on behalf of the ARM pipeline's MEM stage. Each 32-bit load or store becomes two back-to-back 16-bit SRAM accesses: the low half first, then the high half. While an access is in flight the block holds `ready` low so the hazard/freeze logic stalls every pipeline stage. It sits between the MEM stage and the SRAM pins at the top level.

## Interface
- `ADDR_BASE`, default 1024: CPU byte address that maps to SRAM word 0.
- `clk`  in  1: system clock (CLOCK_50 domain).
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: store request from the MEM stage.
- `rd_en`  in  1: load request from the MEM stage.
- `address`  in  32: CPU byte address.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data, registered.
- `ready`  out  1: high means the pipeline may advance. Low means freeze.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: SRAM strobes, active-low.

## Operation
- **States:** IDLE, ACC_LO, ACC_HI, DONE. With the macro enabled, WAIT_LO and WAIT_HI are added (see Configuration).
- **IDLE:**
  - If `wr_en|rd_en`, capture `address`, `wdata` and the op into internal registers, then go to ACC_LO.
  - If both `wr_en` and `rd_en` are high, the request is treated as a write.
- **Sequence:** ACC_LO → ACC_HI → DONE → IDLE. The DONE → IDLE step is unconditional, so the same request is never re-accepted.
- **Address mapping:**
  - word = (addr_q − `ADDR_BASE`)[18:2], modulo 2^17.
  - `SRAM_ADDR` = {word[16:0], 0} during ACC_LO and {word[16:0], 1} during ACC_HI.
  - `address[1:0]` is ignored.
  - No range check is made. Addresses below `ADDR_BASE` wrap.
- **Write:**
  - `SRAM_WE_N`=0 during the ACC states only.
  - `SRAM_DQ` drives wdata_q[15:0] in ACC_LO and wdata_q[31:16] in ACC_HI.
  - `SRAM_DQ` is high-Z in every other state.
- **Read:**
  - `SRAM_OE_N`=0 during the ACC states only.
  - `SRAM_DQ` is sampled into `rdata[15:0]` on the edge leaving ACC_LO and into `rdata[31:16]` on the edge leaving ACC_HI.
  - `rdata` holds its value until the next read completes. Writes never change `rdata`.
- **Constant strobes:** `SRAM_CE_N`, `SRAM_UB_N` and `SRAM_LB_N` are tied to 0.
- **`ready`** is combinational: (IDLE && !`wr_en` && !`rd_en`) || DONE.

## Timing
- **Reset values:** state IDLE, `rdata`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, `ready`=1 when no request is present.
- **Latency:** the request is first seen in cycle C0 (IDLE, `ready`=0).
  - C1 = ACC_LO, C2 = ACC_HI, C3 = DONE (`ready`=1).
  - The pipeline advances at the end of C3.
  - Total is 4 cycles per access. `rdata` is valid during C3.
- **Back-to-back accesses:** the next instruction reaches MEM in the IDLE cycle after DONE, so there is one idle-state cycle between accesses. No bus contention occurs: DQ is released in DONE.
- **Request dropped mid-access:** if `wr_en`/`rd_en` fall mid-access, the access still completes from the captured registers.
- **Reset mid-operation:** `rst_n` low forces IDLE and releases WE_N, OE_N and DQ immediately (asynchronously). A write may leave one half updated.

## Configuration
- **`SRAM_WAIT_STATE_EN` defined:** inserts WAIT_LO after ACC_LO and WAIT_HI after ACC_HI.
  - Address, strobes and DQ drive are held through each wait state.
  - Read samples move to the edges leaving WAIT_LO and WAIT_HI.
  - Latency becomes 6 cycles, with DONE in C5.
- **`SRAM_WAIT_STATE_EN` undefined:** the 4-cycle sequence above. The wait states do not exist in the RTL.

## Test plan
- **Single store:** store `wdata`=0x12345678 at `address`=1024.
  - SRAM[0]=0x5678 and SRAM[1]=0x1234.
  - `SRAM_WE_N` is low in C1 and C2 only.
  - `ready` is 0 in C0–C2 and 1 in C3.
- **Load back:** load from 1024 → `rdata`=0x12345678 in C3, and `SRAM_OE_N` is low in C1–C2.
- **Address mapping:** load from 1028 with SRAM[2]=0xBEEF and SRAM[3]=0xDEAD → `SRAM_ADDR` is 2 then 3, and `rdata`=0xDEADBEEF. Address 1030 gives the same result (low bits ignored).
- **Back-to-back:** store immediately followed by a load to a different word → two complete 4-cycle sequences, and DQ is never driven in DONE/IDLE. A simultaneous `wr_en`+`rd_en` request is executed as a write.
- **Reset mid-access:** pulse `rst_n` low during ACC_HI of a store → `SRAM_WE_N`=1 and DQ=Z within the same cycle, state is IDLE, and `rdata`=0.
- **Wait states:** with `SRAM_WAIT_STATE_EN` defined, repeat the single store and the load back → `ready` rises in C5, and the data is identical to the non-wait case.

Source files
------------

// File: rtl/sram_word_controller.sv
// Two-cycle 16-bit SRAM sequencer for 32-bit MEM-stage loads and stores.
// Define SRAM_WAIT_STATE_EN to hold each half-word access for an extra cycle.
module sram_word_controller #(
   parameter int unsigned ADDR_BASE = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

`ifdef SRAM_WAIT_STATE_EN
   typedef enum logic [2:0] {
      IDLE, ACC_LO, WAIT_LO, ACC_HI, WAIT_HI, DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, ACC_LO, ACC_HI, DONE
   } state_t;
`endif

   localparam logic [31:0] BASE = 32'(ADDR_BASE);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        in_lo, in_hi, acc;
   logic [31:0] off;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        unused_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      in_lo   = 1'b0;
      in_hi   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_en || rd_en) begin
               addr_d  = address;
               wdata_d = wdata;
               wr_d    = wr_en;
               state_d = ACC_LO;
            end
         end
`ifdef SRAM_WAIT_STATE_EN
         ACC_LO: begin
            in_lo   = 1'b1;
            state_d = WAIT_LO;
         end
         WAIT_LO: begin
            in_lo   = 1'b1;
            state_d = ACC_HI;
            if (!wr_q) rdata_d[15:0] = SRAM_DQ;
         end
         ACC_HI: begin
            in_hi   = 1'b1;
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            in_hi   = 1'b1;
            state_d = DONE;
            if (!wr_q) rdata_d[31:16] = SRAM_DQ;
         end
`else
         ACC_LO: begin
            in_lo   = 1'b1;
            state_d = ACC_HI;
            if (!wr_q) rdata_d[15:0] = SRAM_DQ;
         end
         ACC_HI: begin
            in_hi   = 1'b1;
            state_d = DONE;
            if (!wr_q) rdata_d[31:16] = SRAM_DQ;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes and bus drive decode from state only, so reset releases them at once.
   assign acc        = in_lo | in_hi;
   assign off        = addr_q - BASE;
   assign unused_off = ^{off[31:19], off[1:0]};
   assign SRAM_ADDR  = acc ? {off[18:2], in_hi} : '0;
   assign SRAM_WE_N  = !(acc && wr_q);
   assign SRAM_OE_N  = !(acc && !wr_q);
   assign SRAM_CE_N  = 1'b0;
   assign SRAM_UB_N  = 1'b0;
   assign SRAM_LB_N  = 1'b0;
   assign dq_oe      = acc && wr_q;
   assign dq_out     = in_hi ? wdata_q[31:16] : wdata_q[15:0];
   assign SRAM_DQ    = dq_oe ? dq_out : 'z;
   assign rdata      = rdata_q;
   assign ready      = (state_q == IDLE && !wr_en && !rd_en) ||
                       (state_q == DONE);

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: SRAM model, cycle checks, scoreboard.
// Build with SRAM_WAIT_STATE_EN to cover the wait-state sequence.
module tb_sram_word_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   wire  [31:0] rdata;
   wire         ready;
   wire  [15:0] sram_dq;
   wire  [17:0] sram_addr;
   wire         we_n, oe_n, ce_n, ub_n, lb_n;

`ifdef SRAM_WAIT_STATE_EN
   localparam int N = 6;
   localparam int HI_C = 3;
`else
   localparam int N = 4;
   localparam int HI_C = 2;
`endif

   typedef struct {
      bit          is_rd;
      logic [16:0] wd;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem [0:1023];
   logic [15:0] ref_mem [0:1023];
   logic [31:0] last_rd = '0;
   int          n_vec = 0;
   int          n_err = 0;

   sram_word_controller #(.ADDR_BASE(1024)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
      .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n)
   );

   always #5 clk = ~clk;

   // Undriven bus floats high, so a released bus reads 16'hFFFF.
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (sram_dq[i]);
   end

   assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[9:0]] : 'z;

   always @(posedge clk)
      if (!we_n) mem[sram_addr[9:0]] <= sram_dq;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_lo(input int c);
`ifdef SRAM_WAIT_STATE_EN
      return c == 1 || c == 2;
`else
      return c == 1;
`endif
   endfunction

   function automatic bit is_hi(input int c);
`ifdef SRAM_WAIT_STATE_EN
      return c == 3 || c == 4;
`else
      return c == 2;
`endif
   endfunction

   task automatic access(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input bit drop);
      bit          isw;
      bit          isr;
      bit          acc;
      logic [31:0] off;
      logic [16:0] wd;
      logic [9:0]  lo_i;
      logic [9:0]  hi_i;
      exp_t        e;
      isw  = w;
      isr  = r && !w;
      off  = a - 32'd1024;
      wd   = off[18:2];
      lo_i = {wd[8:0], 1'b0};
      hi_i = {wd[8:0], 1'b1};
      wr_en   = w;
      rd_en   = r;
      address = a;
      wdata   = d;
      e.is_rd = isr;
      e.wd    = wd;
      if (isw) begin
         e.val = d;
         ref_mem[lo_i] = d[15:0];
         ref_mem[hi_i] = d[31:16];
      end else begin
         e.val = {ref_mem[hi_i], ref_mem[lo_i]};
      end
      sb.push_back(e);
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         acc = is_lo(c) || is_hi(c);
         chk("ready", 32'(ready), 32'(c == N - 1));
         chk("we_n", 32'(we_n), 32'(!(isw && acc)));
         chk("oe_n", 32'(oe_n), 32'(!(isr && acc)));
         if (acc)
            chk("sram_addr", 32'(sram_addr), 32'({wd, is_hi(c)}));
         if (isw && acc)
            chk("dq_wr", 32'(sram_dq), 32'(is_hi(c) ? d[31:16] : d[15:0]));
         else if (!acc)
            chk("dq_release", 32'(sram_dq), 32'h0000_FFFF);
         if (c == N - 1) begin
            e = sb.pop_front();
            if (e.is_rd) begin
               chk("rdata", rdata, e.val);
               last_rd = e.val;
            end else begin
               chk("mem_lo", 32'(mem[lo_i]), 32'(e.val[15:0]));
               chk("mem_hi", 32'(mem[hi_i]), 32'(e.val[31:16]));
               chk("rdata_hold", rdata, last_rd);
            end
         end
         @(posedge clk);
         #1;
         if (drop && c == 0) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      mem[2] = 16'hBEEF;
      mem[3] = 16'hDEAD;
      ref_mem[2] = 16'hBEEF;
      ref_mem[3] = 16'hDEAD;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq", 32'(sram_dq), 32'h0000_FFFF);
      chk("rst_rdata", rdata, 32'd0);
      chk("tied_n", 32'({ce_n, ub_n, lb_n}), 32'd0);
      @(posedge clk);
      #1;

      access(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b0);
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
      access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
      access(1'b0, 1'b1, 32'd1030, 32'h0, 1'b0);
      access(1'b1, 1'b0, 32'd1040, 32'hCAFE_0123, 1'b0);
      access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
      access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
      access(1'b1, 1'b1, 32'd1048, 32'h0BAD_F00D, 1'b0);
      access(1'b0, 1'b1, 32'd1048, 32'h0, 1'b1);
      access(1'b1, 1'b0, 32'd1020, 32'h7654_3210, 1'b1);
      access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);

      // Store interrupted by reset while the high half is on the bus.
      wr_en   = 1'b1;
      address = 32'd1056;
      wdata   = 32'hA5A5_5A5A;
      @(posedge clk);
      #1 wr_en = 1'b0;
      repeat (HI_C - 1) @(posedge clk);
      #2;
      chk("pre_rst_we_n", 32'(we_n), 32'd0);
      chk("pre_rst_dq", 32'(sram_dq), 32'h0000_A5A5);
      rst_n = 1'b0;
      #1;
      chk("arst_we_n", 32'(we_n), 32'd1);
      chk("arst_oe_n", 32'(oe_n), 32'd1);
      chk("arst_dq", 32'(sram_dq), 32'h0000_FFFF);
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_rdata", rdata, 32'd0);
      #1 rst_n = 1'b1;
      last_rd = '0;
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
